fifo_rd_ctrl: RTL
=================

# fifo_rd_ctrl

Read-side controller for the shared synchronous FIFO. It drains words from the FIFO's read port and presents them on a valid/ready stream to the downstream consumer. It tracks the FIFO's one-cycle read latency and its read-acceptance rule, so every stored word is delivered exactly once, in order, under backpressure. It sits between the FIFO read interface and the consumer; the FIFO width and depth come from the shared package.

## Interface
- FIFO_WIDTH, 16, data word width (matches the FIFO)
- OUT_DEPTH, 3, output buffer entries; the minimum is 3 for full throughput
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  level: permits normal draining
- flush  in  1  pulse: drain the FIFO completely, regardless of en
- fifo_rd_en  out  1  read request to the FIFO
- fifo_data_out  in  FIFO_WIDTH  FIFO read data
- fifo_empty, fifo_full  in  1  FIFO status flags
- fifo_wr_en  in  1  FIFO write enable, monitored to predict read acceptance
- fifo_underflow  in  1  FIFO underflow flag
- m_valid  out  1  output word valid
- m_ready  in  1  consumer ready
- m_data  out  FIFO_WIDTH  output word
- word_count  out  16  count of delivered words
- flush_done  out  1  one-cycle pulse when a flush completes
- underflow_err  out  1  sticky error flag
- busy  out  1  high whenever state != IDLE, or any data is pending or buffered

## Operation
- States:
  - IDLE: no reads issued.
  - RUN: normal draining.
  - FLUSH: draining until the FIFO is empty.
- State transitions:
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0.
  - flush=1 in IDLE or RUN -> FLUSH.
  - flush in FLUSH is ignored. flush has priority over en.
- Read request: fifo_rd_en = (state != IDLE) && !fifo_empty && (occ + pending < OUT_DEPTH).
  - occ is the buffer occupancy; pending is a 1-bit in-flight flag.
  - fifo_rd_en never depends on m_ready.
- Read acceptance, per the FIFO's rule: accepted = fifo_rd_en && !fifo_empty && (!fifo_wr_en || fifo_full).
  - A read issued together with a write to a non-full FIFO is dropped by the FIFO. pending is not set for it.
- pending <= accepted. When pending=1, fifo_data_out is pushed into the buffer tail.
- Buffer: OUT_DEPTH-entry circular buffer.
  - Read and write pointers wrap at OUT_DEPTH-1 -> 0.
  - Push and pop may occur in the same cycle; occ is then unchanged.
- m_valid = (occ != 0); m_data is the buffer head.
  - m_data holds stable while m_valid && !m_ready.
  - A pop occurs on m_valid && m_ready.
- word_count increments on every pop and wraps 0xFFFF -> 0.
- Leaving RUN for IDLE stops new reads only. Pending and buffered words are still delivered.
- FLUSH completes when fifo_empty && !pending && occ == 0. The controller then pulses flush_done for one cycle and enters RUN if en=1, otherwise IDLE.
- fifo_underflow=1 sets underflow_err. The flag clears only on reset; it cannot occur with correct gating.
- Asynchronous reset mid-operation discards pending and buffered data. The reset value of every output is 0:
  - m_valid, m_data, word_count, flush_done, underflow_err, busy are 0.
  - fifo_rd_en is 0, because state is IDLE.

## Timing
- Read latency: fifo_rd_en is accepted in cycle N. The FIFO updates fifo_data_out at the end of N. The buffer captures it at the end of N+1. m_valid=1 in N+2.
- Throughput is 1 word/cycle with m_ready=1 and no concurrent FIFO writes. In steady state occ=1 and pending=1.
- With m_ready=0, at most OUT_DEPTH reads are accepted. fifo_rd_en then stays 0 until a pop occurs.
- flush_done is registered: it is high in the cycle after the completion condition holds.
- Status flags are sampled in the same cycle as fifo_rd_en. No extra registering is applied to FIFO inputs.

## Test plan
- Reset: assert rst_n=0 mid-stream. All outputs are 0 asynchronously; state is IDLE; after release, no spurious m_valid.
- Stream: preload A1..A4 with no writes, set en=1 and m_ready=1. Required response:
  - fifo_rd_en is high for 4 consecutive cycles.
  - m_data is A1..A4 on consecutive cycles, starting 2 cycles after the first rd_en.
  - word_count=4.
- Backpressure: preload 5 words, m_ready=0, en=1. Required response:
  - Exactly 3 reads are accepted, then fifo_rd_en=0.
  - m_data holds word 1.
  - After m_ready=1, all 5 words arrive in order with no duplicates.
- Write collision: FIFO holds 2 words (not full), fifo_wr_en=1 during rd_en. No pending is set and no word is captured; after the write stops, both original words are delivered once each, in order.
- Flush: en=0, preload 3 words, pulse flush with m_ready=1. All 3 words are delivered, flush_done pulses exactly once, and the controller returns to IDLE with busy=0.
- Wrap: stream 10 words with m_ready toggling every cycle. Buffer pointers wrap, the order is preserved, word_count=10, and underflow_err stays 0.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for the shared synchronous FIFO.
// Tracks the FIFO's one-cycle read latency and streams words out on valid/ready.
package fifo_pkg;
    localparam int FIFO_WIDTH_DEF = 16;
endpackage

module fifo_rd_ctrl #(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH_DEF,
    parameter int OUT_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    input  logic                  fifo_wr_en,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [15:0]           word_count,
    output logic                  flush_done,
    output logic                  underflow_err,
    output logic                  busy
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [PW-1:0] PTR_LAST = PW'(OUT_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(OUT_DEPTH);

    logic [1:0]            state_q, state_d;
    logic                  pending_q, pending_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [FIFO_WIDTH-1:0] buf_q [OUT_DEPTH];
    logic [15:0]           word_count_q, word_count_d;
    logic                  flush_done_q, flush_done_d;
    logic                  uflow_q, uflow_d;

    logic                  rd_accept;
    logic                  push;
    logic                  pop;
    logic [CW:0]           in_use;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Words already requested still count against buffer space.
    assign in_use     = {1'b0, occ_q} + (CW + 1)'(pending_q);
    assign fifo_rd_en = (state_q != IDLE) && !fifo_empty && (in_use < DEPTH_C);

    // The FIFO drops a read that collides with a write unless it is full.
    assign rd_accept  = fifo_rd_en && !fifo_empty && (!fifo_wr_en || fifo_full);

    assign push = pending_q;
    assign pop  = m_valid && m_ready;

    assign m_valid       = (occ_q != '0);
    assign m_data        = buf_q[rptr_q];
    assign word_count    = word_count_q;
    assign flush_done    = flush_done_q;
    assign underflow_err = uflow_q;
    assign busy          = (state_q != IDLE) || pending_q || m_valid;

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (fifo_empty && !pending_q && (occ_q == '0)) begin
                    flush_done_d = 1'b1;
                    state_d      = en ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d    = rd_accept;
        wptr_d       = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d       = pop ? ptr_inc(rptr_q) : rptr_q;
        word_count_d = word_count_q + (pop ? 16'd1 : 16'd0);
        uflow_d      = uflow_q | fifo_underflow;
        occ_d        = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            occ_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            word_count_q <= '0;
            flush_done_q <= 1'b0;
            uflow_q      <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            occ_q        <= occ_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            word_count_q <= word_count_d;
            flush_done_q <= flush_done_d;
            uflow_q      <= uflow_d;
            if (push) begin
                buf_q[wptr_q] <= fifo_data_out;
            end
        end
    end

endmodule
